// File: rtl/fine_fifo_reader_pkg.sv
// Shared constants and types for the fine-sync FIFO reader.
// CP handling is selected by the FINE_READER_CP_STRIP_EN macro in fine_fifo_reader.sv.
package fine_fifo_reader_pkg;

    localparam int unsigned FIXED_POINT_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH        = 220;
    localparam int unsigned SYM_LEN           = 64;
    localparam int unsigned CP_LEN            = 16;

    // Read tag carried by the pending register: {discard, first, last, idx}.
    localparam int unsigned TAG_W      = 11;
    // Tag bits carried through the skid buffer alongside data: {first, last, idx}.
    localparam int unsigned SKID_TAG_W = 10;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSkip  = 3'd1,
        StCp    = 3'd2,
        StSym   = 3'd3,
        StDrain = 3'd4
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       discard;
        logic       first;
        logic       last;
        logic [7:0] idx;
    } pend_t;

endpackage

// File: rtl/fine_skid_buf.sv
// Two-entry valid/ready buffer for forwarded samples and their tags; head is always the
// registered oldest entry so outputs stay stable under back-pressure.
module fine_skid_buf
    import fine_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = FIXED_POINT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W+SKID_TAG_W-1:0] push_data,
    input  logic                         pop,
    output logic [DATA_W+SKID_TAG_W-1:0] head_data,
    output logic                         head_valid,
    output logic [1:0]                   count
);

    logic [DATA_W+SKID_TAG_W-1:0] head_q, tail_q;
    logic [1:0]                   cnt_q;
    logic                         pop_eff;

    assign pop_eff = pop && (cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= push_data;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= push_data;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = head_q;
    assign head_valid = (cnt_q != 2'd0);
    assign count      = cnt_q;

endmodule

// File: rtl/fine_fifo_reader.sv
// Read-side controller for the fine-sync sample FIFO: skips the timing offset, then per symbol
// handles the CP and forwards payload. FINE_READER_CP_STRIP_EN drops CP samples when defined.
module fine_fifo_reader
    import fine_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W  = FIXED_POINT_WIDTH,
    parameter int unsigned SYM_LEN = fine_fifo_reader_pkg::SYM_LEN,
    parameter int unsigned CP_LEN  = fine_fifo_reader_pkg::CP_LEN,
    parameter int unsigned CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  timing_offset,
    input  logic [7:0]        n_sym,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_r_valid,
    output logic              fifo_r_en,
    output logic [DATA_W-1:0] sym_data,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              sym_first,
    output logic              sym_last,
    output logic [7:0]        sym_idx,
    output logic              busy,
    output logic              done
);

    state_e           state;
    logic [8:0]       phase;
    logic [7:0]       sym_cnt;
    logic [CNT_W-1:0] off_q;
    logic [7:0]       nsym_q;
    pend_t            pend;

    logic       pop, push, fwd_pend, credit_ok, in_read, phase_end;
    logic       rd_discard, rd_first, rd_last;
    logic [1:0] skid_cnt;
    logic [2:0] occ;
    logic       unused_fifo_count;

    assign unused_fifo_count = ^fifo_count;

    assign pop      = sym_valid && sym_ready;
    assign fwd_pend = pend.valid && !pend.discard;
    assign occ      = {1'b0, skid_cnt} + {2'b00, fwd_pend};
    // Skid occupancy plus the in-flight forward read must leave room after this cycle's pop.
    assign credit_ok = occ < (3'd2 + {2'b00, pop});
    assign in_read   = (state == StSkip) || (state == StCp) || (state == StSym);
    assign fifo_r_en = in_read && !fifo_empty && (rd_discard || credit_ok);

    always_comb begin
        rd_discard = 1'b0;
        rd_first   = 1'b0;
        rd_last    = 1'b0;
        phase_end  = 1'b0;
        case (state)
            StSkip: begin
                rd_discard = 1'b1;
                phase_end  = (phase == 9'(off_q) - 9'd1);
            end
            StCp: begin
`ifdef FINE_READER_CP_STRIP_EN
                rd_discard = 1'b1;
`else
                rd_first   = (phase == 9'd0);
`endif
                phase_end  = (phase == 9'(CP_LEN - 1));
            end
            StSym: begin
`ifdef FINE_READER_CP_STRIP_EN
                rd_first   = (phase == 9'd0);
`endif
                rd_last    = (phase == 9'(SYM_LEN - 1));
                phase_end  = rd_last;
            end
            default: ;
        endcase
    end

    assign push = fifo_r_valid && pend.valid && !pend.discard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            phase   <= 9'd0;
            sym_cnt <= 8'd0;
            off_q   <= '0;
            nsym_q  <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pend    <= '0;
        end else begin
            done <= 1'b0;
            // Every issued read returns exactly one cycle later, so the tag lives one cycle.
            pend <= fifo_r_en ? pend_t'{1'b1, rd_discard, rd_first, rd_last, sym_cnt} : '0;
            case (state)
                StIdle: begin
                    if (start) begin
                        off_q   <= timing_offset;
                        nsym_q  <= n_sym;
                        busy    <= 1'b1;
                        phase   <= 9'd0;
                        sym_cnt <= 8'd0;
                        if (n_sym == 8'd0) begin
                            state <= StDrain;
                        end else if (timing_offset != '0) begin
                            state <= StSkip;
                        end else begin
                            state <= StCp;
                        end
                    end
                end
                StSkip, StCp, StSym: begin
                    if (fifo_r_en) begin
                        if (phase_end) begin
                            phase <= 9'd0;
                            if (state == StSkip) begin
                                state <= StCp;
                            end else if (state == StCp) begin
                                state <= StSym;
                            end else begin
                                sym_cnt <= sym_cnt + 8'd1;
                                state   <= (sym_cnt + 8'd1 == nsym_q) ? StDrain : StCp;
                            end
                        end else begin
                            phase <= phase + 9'd1;
                        end
                    end
                end
                StDrain: begin
                    if (!pend.valid && (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && pop))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    fine_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ({fifo_dout, pend.first, pend.last, pend.idx}),
        .pop        (pop),
        .head_data  ({sym_data, sym_first, sym_last, sym_idx}),
        .head_valid (sym_valid),
        .count      (skid_cnt)
    );

endmodule

// File: tb/tb_fine_fifo_reader.sv
// Scoreboard bench for fine_fifo_reader: ramp-filled FIFO model, frame-level reference model.
module tb_fine_fifo_reader;

    localparam int CPL  = 16;
    localparam int SYML = 64;
    localparam int SL   = CPL + SYML;

    logic        clk = 1'b0;
    logic        rst_n, start, fifo_empty, fifo_r_valid, fifo_r_en;
    logic [8:0]  timing_offset, fifo_count;
    logic [7:0]  n_sym, sym_idx;
    logic [15:0] fifo_dout, sym_data;
    logic        sym_valid, sym_ready, sym_first, sym_last, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd = 0;
    int wr = 0;
    int frame_base = 0;
    int off_m = 0;
    int n_m = 0;
    int fwd_issued = 0;
    int popped = 0;
    int last_pop_cyc = -10;
    int rdy_mode = 0;
    logic spur = 1'b0;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    fine_fifo_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .timing_offset (timing_offset),
        .n_sym         (n_sym),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .fifo_dout     (fifo_dout),
        .fifo_r_valid  (fifo_r_valid),
        .fifo_r_en     (fifo_r_en),
        .sym_data      (sym_data),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .sym_first     (sym_first),
        .sym_last      (sym_last),
        .sym_idx       (sym_idx),
        .busy          (busy),
        .done          (done)
    );

    assign fifo_empty = (rd >= wr);
    assign fifo_count = 9'(((wr - rd) > 220) ? 220 : (wr - rd));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Does read number k of the current frame produce an output sample?
    function automatic bit is_fwd(input int k);
        if (k < off_m || k >= off_m + n_m * SL) return 1'b0;
`ifdef FINE_READER_CP_STRIP_EN
        return ((k - off_m) % SL) >= CPL;
`else
        return 1'b1;
`endif
    endfunction

    // FIFO model: sample value equals its absolute read index.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r_en) begin
            rd           <= rd + 1;
            fifo_r_valid <= 1'b1;
            fifo_dout    <= 16'(rd);
        end else begin
            fifo_r_valid <= spur;
            fifo_dout    <= 16'hDEAD;
        end
        if (!rst_n) begin
            fwd_issued <= 0;
            popped     <= 0;
        end else begin
            if (fifo_r_en && is_fwd(rd - frame_base)) fwd_issued <= fwd_issued + 1;
            if (sym_valid && sym_ready) popped <= popped + 1;
        end
    end

    initial begin
        sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sym_ready = 1'b1;
                1:       sym_ready = (cyc % 3 == 0);
                default: sym_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard, stall stability, credit bound, honoured reads, reset values.
    initial begin
        logic        prev_rst = 1'b1;
        logic        held_v = 1'b0;
        logic [25:0] held = '0;
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                check("reset_outputs", {fifo_r_en, sym_valid, sym_first, sym_last, busy, done,
                                        sym_idx, sym_data}, 64'd0);
            end
            if (held_v) begin
                check("stall_stable", {sym_valid, sym_data, sym_first, sym_last, sym_idx},
                      {1'b1, held});
            end
            if (fifo_r_en) check("read_while_empty", fifo_empty, 1'b0);
            if (busy) check("credit_bound", 64'((fwd_issued - popped) <= 2), 64'd1);
            if (rst_n && sym_valid && sym_ready) begin
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {sym_data, sym_first, sym_last, sym_idx}, 64'd0);
                    failures += (sym_data == 16'd0) ? 1 : 0;
                end else begin
                    e = exp_q.pop_front();
                    check("sample", {sym_data, sym_first, sym_last, sym_idx}, e);
                end
            end
            held_v   = rst_n && sym_valid && !sym_ready;
            held     = {sym_data, sym_first, sym_last, sym_idx};
            prev_rst = rst_n;
        end
    end

    task automatic start_frame(input int off, input int n);
        int fj;
        @(posedge clk);
        #1;
        frame_base = rd;
        off_m      = off;
        n_m        = n;
`ifdef FINE_READER_CP_STRIP_EN
        fj = CPL;
`else
        fj = 0;
`endif
        for (int s = 0; s < n; s++) begin
            for (int j = fj; j < SL; j++) begin
                exp_q.push_back({16'(frame_base + off + s * SL + j), (j == fj), (j == SL - 1),
                                 8'(s)});
            end
        end
        timing_offset = 9'(off);
        n_sym         = 8'(n);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        if (ok) begin
            check("done_after_last_pop", 64'(cyc - last_pop_cyc), 64'd1);
            check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
            check("read_total", 64'(rd - frame_base), 64'(off_m + n_m * SL));
            check("busy_cleared", 64'(busy), 64'd0);
        end
    endtask

    task automatic run_frame(input int off, input int n, input int mode);
        rdy_mode = mode;
        start_frame(off, n);
        wait_done((off + n * SL) * 4 + 100);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        timing_offset = '0;
        n_sym = '0;
        wr = 201;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pre-filled ramp 0..200, offset 5, two symbols, ready always high.
        run_frame(5, 2, 0);

        @(posedge clk);
        #1;
        wr = rd + 100000;
        // 1-of-3 ready and random ready with random offsets.
        run_frame(int'($urandom_range(0, 20)), 3, 1);
        run_frame(int'($urandom_range(1, 20)), 2, 2);

        // FIFO runs dry in the middle of symbol 1's CP, then refills.
        @(posedge clk);
        #1;
        wr = rd + 3 + SL + 8;
        rdy_mode = 2;
        start_frame(3, 2);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rd == wr) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_reached", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("reads_held_while_empty", 64'(rd - frame_base), 64'(3 + SL + 8));
        wr = rd + 100000;
        wait_done(1000);

        // Zero symbols: done two cycles after start, no reads.
        rdy_mode = 0;
        start_frame(7, 0);
        @(negedge clk);
        check("nsym0_busy", {busy, done}, 2'b10);
        @(negedge clk);
        check("nsym0_done", {busy, done}, 2'b01);
        check("nsym0_reads", 64'(rd - frame_base), 64'd0);

        // Offset zero, single symbol.
        run_frame(0, 1, 0);

        // Reset during a later symbol with a read in flight.
        rdy_mode = 2;
        start_frame(0, 3);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((rd - frame_base) >= SL + CPL + 20 && fifo_r_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("reset_point_reached", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_frame(2, 1, 0);

        // A few random frames.
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(0, 30)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
